pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Drives the hold (Stall_ID) and flush (PCSel) inputs of the IF/ID register, the PC write enable, the ID/EX bubble insert and a back-end freeze. Handles three hazard classes:
- load-use hazards
- taken branches/jumps resolved in ID
- multi-cycle data-memory accesses

Also keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_hazard_controller.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// instruction field positions and the load-use hazard test.
// Imported by the controller top; holds no logic of its own.
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // rt is compared even for instructions that do not read it; a spurious
   // stall costs one cycle, a missed one corrupts data.
   function automatic logic load_use(input logic        mem_read,
                                     input logic [4:0]  write_reg,
                                     input logic [31:0] instr);
      logic [4:0] rs;
      logic [4:0] rt;
      rs = instr[RS_HI:RS_LO];
      rt = instr[RT_HI:RT_LO];
      return mem_read && (write_reg != REG_ZERO) &&
             ((write_reg == rs) || (write_reg == rt));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug events.
// Latency: count reflects an increment one cycle after inc.
// No backpressure; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count events, sticking at the maximum value once reached.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for load-use, taken-branch and multi-cycle memory hazards.
// Latency: control outputs are Mealy (same cycle); event counters lag one cycle.
// No backpressure; a memory wait freezes the whole pipe for MEM_LATENCY-1 cycles.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [31:0]      Instr_ID,
   input  logic             MemRead_EX,
   input  logic [4:0]       WriteReg_EX,
   input  logic             BranchTaken,
   input  logic             MemStart,
   output logic             PCWrite,
   output logic             Stall_ID,
   output logic             PCSel_IFID,
   output logic             Bubble_EX,
   output logic             Freeze,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // The entry cycle in RUN is already the first frozen cycle, so a
   // two-cycle memory needs no MEMWAIT residency at all.
   localparam logic       MEM_STALLS = (MEM_LATENCY > 1);
   localparam logic       HAS_WAIT   = (MEM_LATENCY > 2);
   localparam logic [3:0] WAIT_LOAD  = 4'(MEM_LATENCY - 1);

   state_t     state;
   logic [3:0] wait_cnt;
   logic       luh;
   logic       mem_go;

   // Opcode and immediate bits play no part in hazard detection.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{Instr_ID[31:26], Instr_ID[15:0]};

   assign luh    = load_use(MemRead_EX, WriteReg_EX, Instr_ID);
   assign mem_go = MemStart && MEM_STALLS;

   // Output decode: reset clears IF/ID and ID/EX, then memory wait beats
   // load-use beats branch; a held ID stage always wins over a flush.
   always_comb begin
      PCWrite    = 1'b1;
      Stall_ID   = 1'b0;
      PCSel_IFID = 1'b0;
      Bubble_EX  = 1'b0;
      Freeze     = 1'b0;
      if (Reset) begin
         PCWrite    = 1'b0;
         PCSel_IFID = 1'b1;
         Bubble_EX  = 1'b1;
      end else if (state == MEMWAIT) begin
         PCWrite  = 1'b0;
         Stall_ID = 1'b1;
         Freeze   = 1'b1;
      end else if (mem_go) begin
         PCWrite  = 1'b0;
         Stall_ID = 1'b1;
         Freeze   = 1'b1;
      end else if (luh) begin
         PCWrite   = 1'b0;
         Stall_ID  = 1'b1;
         Bubble_EX = 1'b1;
      end else if (BranchTaken) begin
         PCSel_IFID = 1'b1;
      end
   end

   // Sequencer: the wait counter holds the frozen cycles left for this
   // access counting the entry cycle; leave once only that one remains.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= RUN;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            RUN: begin
               if (mem_go) begin
                  wait_cnt <= WAIT_LOAD;
                  if (HAS_WAIT) begin
                     state <= MEMWAIT;
                  end
               end
            end
            MEMWAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd2) begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .Clock (Clock),
      .Reset (Reset),
      .inc   (~PCWrite),
      .count (StallCount)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .Clock (Clock),
      .Reset (Reset),
      .inc   (PCSel_IFID),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller (MEM_LATENCY=4, CNT_W=4).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Control order in expectations: {PCWrite, Stall_ID, PCSel_IFID, Bubble_EX, Freeze}.
module tb_pipeline_hazard_controller;

   localparam int ML = 4;
   localparam int CW = 4;

   localparam logic [4:0] C_RUN = 5'b10000;
   localparam logic [4:0] C_LUH = 5'b01010;
   localparam logic [4:0] C_BR  = 5'b10100;
   localparam logic [4:0] C_FRZ = 5'b01001;
   localparam logic [4:0] C_RST = 5'b00110;

   typedef struct {
      logic [4:0]    ctl;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
      string         name;
   } exp_t;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [31:0]   Instr_ID;
   logic          MemRead_EX;
   logic [4:0]    WriteReg_EX;
   logic          BranchTaken;
   logic          MemStart;
   logic          PCWrite;
   logic          Stall_ID;
   logic          PCSel_IFID;
   logic          Bubble_EX;
   logic          Freeze;
   logic [CW-1:0] StallCount;
   logic [CW-1:0] FlushCount;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   pipeline_hazard_controller #(.MEM_LATENCY(ML), .CNT_W(CW)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Instr_ID    (Instr_ID),
      .MemRead_EX  (MemRead_EX),
      .WriteReg_EX (WriteReg_EX),
      .BranchTaken (BranchTaken),
      .MemStart    (MemStart),
      .PCWrite     (PCWrite),
      .Stall_ID    (Stall_ID),
      .PCSel_IFID  (PCSel_IFID),
      .Bubble_EX   (Bubble_EX),
      .Freeze      (Freeze),
      .StallCount  (StallCount),
      .FlushCount  (FlushCount)
   );

   always #5 Clock = ~Clock;

   // Apply one cycle of inputs and queue what the outputs must be in that cycle.
   task automatic step(input logic rst, input logic mr, input logic [4:0] wr,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic bt, input logic ms, input logic [4:0] ctl,
                       input int sc, input int fc, input string name);
      exp_t e;
      Reset       = rst;
      MemRead_EX  = mr;
      WriteReg_EX = wr;
      Instr_ID    = {6'h23, rs, rt, 16'h1234};
      BranchTaken = bt;
      MemStart    = ms;
      e.ctl  = ctl;
      e.sc   = CW'(sc);
      e.fc   = CW'(fc);
      e.name = name;
      sb.push_back(e);
      @(posedge Clock);
      #1;
   endtask

   // Monitor: outputs are valid every cycle, sampled mid-cycle.
   initial begin
      exp_t       e;
      logic [4:0] act;
      forever begin
         @(negedge Clock);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {PCWrite, Stall_ID, PCSel_IFID, Bubble_EX, Freeze};
            vectors++;
            if ((act !== e.ctl) || (StallCount !== e.sc) || (FlushCount !== e.fc)) begin
               miscompares++;
               $display("FAIL %s: got ctl=%b stall_cnt=%0d flush_cnt=%0d, want ctl=%b stall_cnt=%0d flush_cnt=%0d",
                        e.name, act, StallCount, FlushCount, e.ctl, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      Reset       = 1'b1;
      MemRead_EX  = 1'b0;
      WriteReg_EX = 5'd0;
      Instr_ID    = 32'd0;
      BranchTaken = 1'b0;
      MemStart    = 1'b0;
      @(posedge Clock);
      #1;

      //   rst mr  wr  rs  rt  bt ms  ctl    sc fc  name
      step(1, 0,  0,  0,  0, 0, 0, C_RST, 0, 0, "reset_1");
      step(1, 0,  0,  0,  0, 0, 0, C_RST, 0, 0, "reset_2");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 0, 0, "run_idle");
      step(0, 1,  8,  8,  3, 0, 0, C_LUH, 0, 0, "luh_rs");
      step(0, 0,  8,  8,  3, 0, 0, C_RUN, 1, 0, "after_luh");
      step(0, 1,  0,  0,  0, 0, 0, C_RUN, 1, 0, "luh_r0");
      step(0, 0,  0,  1,  2, 1, 0, C_BR,  1, 0, "branch");
      step(0, 0,  0,  1,  2, 0, 0, C_RUN, 1, 1, "after_branch");
      step(0, 1,  9,  2,  9, 1, 0, C_LUH, 1, 1, "br_luh_rt");
      step(0, 0,  9,  2,  9, 1, 0, C_BR,  2, 1, "br_retry");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 2, 2, "idle_pre_mem");
      step(0, 1,  5,  5,  0, 1, 1, C_FRZ, 2, 2, "mem_entry");
      step(0, 0,  0,  0,  0, 1, 1, C_FRZ, 3, 2, "memwait_1");
      step(0, 0,  0,  0,  0, 1, 0, C_FRZ, 4, 2, "memwait_2");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 5, 2, "mem_done");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 5, 2, "idle_post_mem");

      for (int i = 0; i < 20; i++) begin
         step(0, 1, 8, 8, 0, 0, 0, C_LUH, (5 + i > 15) ? 15 : 5 + i, 2, "luh_sat");
      end
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 15, 2, "sat_hold");
      step(0, 1, 12,  0, 12, 0, 0, C_LUH, 15, 2, "sat_luh_again");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 15, 2, "sat_no_wrap");

      step(0, 0,  0,  0,  0, 0, 1, C_FRZ, 15, 2, "mem_entry_2");
      step(1, 0,  0,  0,  0, 1, 0, C_RST, 15, 2, "rst_in_wait");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 0, 0, "post_rst_run");
      step(0, 0,  0,  0,  0, 0, 0, C_RUN, 0, 0, "post_rst_idle");

      for (int i = 0; i < 10 && sb.size() > 0; i++) begin
         @(negedge Clock);
      end
      #2;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
